// File: rtl/bit_block_sched.sv
// Frame-level round-robin scheduler sharing one bit_block_counter between two
// requesters. Accepted words are issued to the counter; a tag pipe running in
// parallel with the counter routes each result back to its owner's total.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no frame owner; arbitrate on valid, ties broken by prio
// OWN0  | requester 0 owns the counter until its last word
// OWN1  | requester 1 owns the counter until its last word
module bit_block_sched #(
    parameter int FF_DLY  = 1,
    parameter int CNT_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req0_data,
    input  logic        req0_valid,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic [31:0] req1_data,
    input  logic        req1_valid,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic [31:0] cnt_data,
    output logic        cnt_enb,
    input  logic [3:0]  cnt_block,
    input  logic        cnt_valid,
    output logic        done0,
    output logic [7:0]  sum0,
    output logic        done1,
    output logic [7:0]  sum1,
    output logic        err
);

    // The counter latency is bounded by the tag pipe depth; FF_DLY is a
    // simulation-only notion and never becomes a real delay in this netlist.
    if (CNT_LAT < 1 || CNT_LAT > 8 || FF_DLY < 0) begin : g_param_check
        $error("bit_block_sched: CNT_LAT must be 1..8 and FF_DLY non-negative");
    end

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t      state, state_nxt;
    logic        prio, prio_nxt;
    logic        accept;
    logic        acc_id;
    logic        acc_last;
    logic [31:0] acc_word;

    // tag bits: [2] valid, [1] requester id, [0] last word of frame
    logic [2:0]               tag_iss;
    logic [CNT_LAT-1:0][2:0]  tag_pipe;
    logic                     tag_v, tag_id, tag_last;
    logic                     res;

    logic [7:0] acc0, acc1;
    logic       first0, first1;
    logic [7:0] res_base;
    logic [8:0] res_raw;
    logic [7:0] res_total;

    // Ready is a pure decode of ownership so it never depends on valid.
    assign req0_ready = (state == OWN0);
    assign req1_ready = (state == OWN1);

    // Arbitration, frame ownership and selection of the accepted word.
    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        accept    = 1'b0;
        acc_id    = 1'b0;
        acc_last  = 1'b0;
        acc_word  = req0_data;
        case (state)
            IDLE: begin
                if (req0_valid && !req1_valid)      state_nxt = OWN0;
                else if (req1_valid && !req0_valid) state_nxt = OWN1;
                else if (req0_valid && req1_valid)  state_nxt = prio ? OWN1 : OWN0;
            end
            OWN0: begin
                accept   = req0_valid;
                acc_last = req0_last;
                if (req0_valid && req0_last) begin
                    state_nxt = IDLE;
                    prio_nxt  = 1'b1;
                end
            end
            OWN1: begin
                accept   = req1_valid;
                acc_id   = 1'b1;
                acc_last = req1_last;
                acc_word = req1_data;
                if (req1_valid && req1_last) begin
                    state_nxt = IDLE;
                    prio_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
        end
    end

    // Issue stage: the counter word and its tag are registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_data <= 32'd0;
            cnt_enb  <= 1'b0;
            tag_iss  <= 3'd0;
        end else begin
            cnt_enb <= accept;
            tag_iss <= {accept, acc_id, acc_last};
            if (accept) cnt_data <= acc_word;
        end
    end

    // Tag delay line matching the counter latency, so its tail lines up with cnt_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= tag_iss;
            for (int i = 1; i < CNT_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tag_v    = tag_pipe[CNT_LAT-1][2];
    assign tag_id   = tag_pipe[CNT_LAT-1][1];
    assign tag_last = tag_pipe[CNT_LAT-1][0];
    assign res      = cnt_valid & tag_v;

    // Saturating running total for whichever requester owns the returning result.
    always_comb begin
        res_base = 8'd0;
        if (tag_id) begin
            if (!first1) res_base = acc1;
        end else begin
            if (!first0) res_base = acc0;
        end
        res_raw   = {1'b0, res_base} + {5'd0, cnt_block};
        res_total = res_raw[8] ? 8'hFF : res_raw[7:0];
    end

    // Per-requester accumulation and frame-done publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc0   <= 8'd0;
            acc1   <= 8'd0;
            first0 <= 1'b1;
            first1 <= 1'b1;
            sum0   <= 8'd0;
            sum1   <= 8'd0;
            done0  <= 1'b0;
            done1  <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            if (res) begin
                if (tag_id) begin
                    acc1   <= res_total;
                    first1 <= tag_last;
                    if (tag_last) begin
                        sum1  <= res_total;
                        done1 <= 1'b1;
                    end
                end else begin
                    acc0   <= res_total;
                    first0 <= tag_last;
                    if (tag_last) begin
                        sum0  <= res_total;
                        done0 <= 1'b1;
                    end
                end
            end
        end
    end

    // Sticky flag for any disagreement between the counter and the tag pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else if (cnt_valid != tag_v) err <= 1'b1;
    end

endmodule

// File: tb/tb_bit_block_sched.sv
// Bench for bit_block_sched: a behavioural bit_block_counter model feeds the
// DUT; frame drivers push expected totals into a scoreboard that a monitor
// drains whenever done0/done1 fires.
module tb_bit_block_sched;

    localparam int CNT_LAT = 3;

    logic        clk, rst_n;
    logic [31:0] req0_data, req1_data;
    logic        req0_valid, req0_last, req0_ready;
    logic        req1_valid, req1_last, req1_ready;
    logic [31:0] cnt_data;
    logic        cnt_enb;
    logic [3:0]  cnt_block;
    logic        cnt_valid;
    logic        done0, done1;
    logic [7:0]  sum0, sum1;
    logic        err;

    bit_block_sched #(.FF_DLY(1), .CNT_LAT(CNT_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
        .cnt_data(cnt_data), .cnt_enb(cnt_enb), .cnt_block(cnt_block), .cnt_valid(cnt_valid),
        .done0(done0), .sum0(sum0), .done1(done1), .sum1(sum1), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int blocks(input logic [31:0] w);
        int   n = 0;
        logic prev = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (w[i] && !prev) n++;
            prev = w[i];
        end
        return n;
    endfunction

    // Counter model, advanced on the falling edge: a word seen with cnt_enb after
    // rising edge a returns as cnt_valid sampled by the DUT at edge a+CNT_LAT+1.
    logic       pv [0:CNT_LAT];
    logic [3:0] pb [0:CNT_LAT];
    logic       spur;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j <= CNT_LAT; j++) begin
                pv[j] = 1'b0;
                pb[j] = 4'd0;
            end
        end else begin
            for (int j = CNT_LAT; j > 0; j--) begin
                pv[j] = pv[j-1];
                pb[j] = pb[j-1];
            end
            pv[0] = cnt_enb;
            pb[0] = cnt_enb ? 4'(blocks(cnt_data)) : 4'd0;
        end
    end

    assign cnt_valid = pv[CNT_LAT] | spur;
    assign cnt_block = pb[CNT_LAT];

    typedef struct {
        int id;
        int sum;
        int due;
    } exp_t;

    exp_t sbq[$];

    // Monitor: every done pulse must match the oldest expected frame total.
    always @(negedge clk) begin
        if (rst_n && (done0 || done1)) begin
            check("done_exclusive", {31'd0, done0 & done1}, 32'd0);
            if (sbq.size() == 0) begin
                check("unexpected_done", {30'd0, done1, done0}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("done_id", done1 ? 32'd1 : 32'd0, e.id);
                check("done_sum", done1 ? {24'd0, sum1} : {24'd0, sum0}, e.sum);
                check("done_cycle", cyc, e.due);
            end
        end
    end

    logic [31:0] fw0 [0:79];
    logic [31:0] fw1 [0:79];
    int first_acc [0:1];
    int last_acc  [0:1];

    task automatic drive(input int id, input logic v, input logic [31:0] d, input logic l);
        if (id == 0) begin
            req0_valid = v; req0_data = d; req0_last = l;
        end else begin
            req1_valid = v; req1_data = d; req1_last = l;
        end
    endtask

    function automatic logic rdy(input int id);
        return (id == 0) ? req0_ready : req1_ready;
    endfunction

    // Sends words [start, start+n) of the requester's table; called at a falling edge.
    // stall_at>0 drops valid for 5 cycles before that word (requester 1 only);
    // abort_after>0 returns with valid still high after that many accepts.
    task automatic send_frame(input int id, input int start, input int n,
                              input int stall_at, input int abort_after);
        int          sum = 0;
        int          guard;
        logic [31:0] w;
        for (int k = 0; k < n; k++) begin
            if (stall_at != 0 && k == stall_at) begin
                for (int s = 0; s < 5; s++) begin
                    drive(id, 1'b0, 32'd0, 1'b0);
                    req0_valid = 1'b1;
                    check("stall_ready0_low", {31'd0, req0_ready}, 32'd0);
                    check("stall_ready1_held", {31'd0, req1_ready}, 32'd1);
                    @(negedge clk);
                end
                req0_valid = 1'b0;
            end
            w = (id == 0) ? fw0[start+k] : fw1[start+k];
            drive(id, 1'b1, w, k == n-1);
            guard = 0;
            while (rdy(id) !== 1'b1 && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 300) begin
                check("grant_timeout", guard, 32'd0);
                drive(id, 1'b0, 32'd0, 1'b0);
                return;
            end
            sum += blocks(w);
            if (sum > 255) sum = 255;
            if (k == 0) first_acc[id] = cyc + 1;
            last_acc[id] = cyc + 1;
            if (k == n-1) sbq.push_back('{id, sum, cyc + 1 + CNT_LAT + 1});
            @(negedge clk);
            if (abort_after == k + 1) return;
        end
        drive(id, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic drain(input string name);
        repeat (CNT_LAT + 6) @(negedge clk);
        check(name, sbq.size(), 32'd0);
    endtask

    int t0, a_first, a_last, c_first, b_first;

    initial begin
        rst_n = 1'b0;
        spur  = 1'b0;
        drive(0, 1'b0, 32'd0, 1'b0);
        drive(1, 1'b0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);

        check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        check("rst_cnt_enb",    {31'd0, cnt_enb}, 32'd0);
        check("rst_cnt_data",   cnt_data, 32'd0);
        check("rst_done",       {30'd0, done1, done0}, 32'd0);
        check("rst_sum0",       {24'd0, sum0}, 32'd0);
        check("rst_sum1",       {24'd0, sum1}, 32'd0);
        check("rst_err",        {31'd0, err}, 32'd0);

        // Contention from reset: req0 frame A then B, req1 frame C; expect A, C, B.
        fw0[0] = 32'hFFFF_FFFF;
        fw0[1] = 32'h0000_0000;
        fw0[2] = 32'hF0F0_F0F0;
        fw1[0] = 32'hF0F0_F0F0;
        rst_n = 1'b1;
        t0 = cyc;
        fork
            begin
                send_frame(0, 0, 2, 0, 0);
                a_first = first_acc[0];
                a_last  = last_acc[0];
                send_frame(0, 2, 1, 0, 0);
                b_first = first_acc[0];
            end
            begin
                send_frame(1, 0, 1, 0, 0);
                c_first = first_acc[1];
            end
        join
        check("req0_granted_first", a_first, t0 + 2);
        check("req1_after_one_idle", c_first, a_last + 2);
        check("rr_req1_wins_next", b_first, c_first + 2);
        drain("drain_contention");

        // Single-word frame.
        fw0[0] = 32'hF0F0_F0F0;
        send_frame(0, 0, 1, 0, 0);
        drain("drain_single");

        // Saturating 70-word frame: 280 blocks clamps to 255.
        for (int i = 0; i < 70; i++) fw0[i] = 32'hF0F0_F0F0;
        send_frame(0, 0, 70, 0, 0);
        check("sat_back_to_back", last_acc[0] - first_acc[0], 32'd69);
        drain("drain_saturation");

        // Stall mid-frame on requester 1 (4+1+2+2 = 9).
        fw1[0] = 32'hF0F0_F0F0;
        fw1[1] = 32'h0000_000F;
        fw1[2] = 32'h8000_0001;
        fw1[3] = 32'h00FF_00FF;
        send_frame(1, 0, 4, 2, 0);
        drain("drain_stall");

        // Spurious counter result with no tag behind it.
        check("err_clear_before_fault", {31'd0, err}, 32'd0);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        check("err_set_after_fault", {31'd0, err}, 32'd1);
        repeat (6) @(negedge clk);
        check("err_sticky", {31'd0, err}, 32'd1);
        check("sum0_after_sat", {24'd0, sum0}, 32'd255);

        // Reset in the middle of a requester 0 frame.
        for (int i = 0; i < 4; i++) fw0[i] = 32'h0F0F_0000 + i;
        send_frame(0, 0, 4, 0, 2);
        rst_n = 1'b0;
        drive(0, 1'b0, 32'd0, 1'b0);
        #1;
        check("mid_rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("mid_rst_cnt_enb",    {31'd0, cnt_enb}, 32'd0);
        check("mid_rst_cnt_data",   cnt_data, 32'd0);
        check("mid_rst_sum0",       {24'd0, sum0}, 32'd0);
        check("mid_rst_sum1",       {24'd0, sum1}, 32'd0);
        check("mid_rst_err",        {31'd0, err}, 32'd0);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fw0[0] = 32'h0000_0003;
        send_frame(0, 0, 1, 0, 0);
        drain("drain_after_reset");
        check("err_after_reset", {31'd0, err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
